// File: rtl/ctrl_pkg.sv
// Shared RV32I control encodings for the decode stage: opcodes, ALU/EXT/NPC/WD/DM codes and the control bundle.
// The M-extension codes are only produced when CTRL_M_EXT_EN is defined.
package ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [4:0] ALU_NOP   = 5'b00000;
    localparam logic [4:0] ALU_LUI   = 5'b00001;
    localparam logic [4:0] ALU_AUIPC = 5'b00010;
    localparam logic [4:0] ALU_ADD   = 5'b00011;
    localparam logic [4:0] ALU_SUB   = 5'b00100;
    localparam logic [4:0] ALU_BEQ   = 5'b00100;
    localparam logic [4:0] ALU_BNE   = 5'b00101;
    localparam logic [4:0] ALU_BLT   = 5'b00110;
    localparam logic [4:0] ALU_BGE   = 5'b00111;
    localparam logic [4:0] ALU_BLTU  = 5'b01000;
    localparam logic [4:0] ALU_BGEU  = 5'b01001;
    localparam logic [4:0] ALU_SLT   = 5'b01010;
    localparam logic [4:0] ALU_SLTU  = 5'b01011;
    localparam logic [4:0] ALU_XOR   = 5'b01100;
    localparam logic [4:0] ALU_OR    = 5'b01101;
    localparam logic [4:0] ALU_AND   = 5'b01110;
    localparam logic [4:0] ALU_SLL   = 5'b01111;
    localparam logic [4:0] ALU_SRL   = 5'b10000;
    localparam logic [4:0] ALU_SRA   = 5'b10001;
    // MUL..REMU occupy ALU_MUL + funct3, i.e. 10010..11001.
    localparam logic [4:0] ALU_MUL   = 5'b10010;

    localparam logic [5:0] EXT_NONE  = 6'b000000;
    localparam logic [5:0] EXT_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_I     = 6'b010000;
    localparam logic [5:0] EXT_S     = 6'b001000;
    localparam logic [5:0] EXT_B     = 6'b000100;
    localparam logic [5:0] EXT_U     = 6'b000010;
    localparam logic [5:0] EXT_J     = 6'b000001;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JAL    = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam logic [2:0] DM_W  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_HU = 3'b010;
    localparam logic [2:0] DM_B  = 3'b011;
    localparam logic [2:0] DM_BU = 3'b100;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic [5:0] ext_op;
        logic [4:0] alu_op;
        logic [2:0] npc_op;
        logic [1:0] wd_sel;
        logic [2:0] dm_ctrl;
        logic       illegal;
        logic       multicycle;
    } ctrl_t;

    localparam int    CTRL_W   = $bits(ctrl_t);
    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic {
        ST_RUN,
        ST_BUBBLE
    } state_e;

    // Register-register and register-immediate ALU ops share the funct3 mapping.
    function automatic logic [4:0] alu_base(input logic [2:0] funct3);
        logic [4:0] op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_ctrl_comb.sv
// Combinational RV32I decoder: raw instruction to control bundle, illegal flag and source-register usage.
// Defining CTRL_M_EXT_EN enables decoding of MUL..REMU; otherwise those encodings are illegal.
module decode_ctrl_comb
    import ctrl_pkg::*;
(
    input  logic [31:0]       instr_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              uses_rs1_o,
    output logic              uses_rs2_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    ctrl_t      ctrl;
    logic       legal;
    logic       uses_rs1;
    logic       uses_rs2;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rd_o   = instr_i[11:7];
    assign rs1_o  = instr_i[19:15];
    assign rs2_o  = instr_i[24:20];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no decode path can infer a latch.
        ctrl     = CTRL_NOP;
        legal    = 1'b1;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_R: begin
                ctrl.reg_write = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                if (funct7 == F7_BASE) begin
                    ctrl.alu_op = alu_base(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    ctrl.alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    ctrl.alu_op = ALU_SRA;
`ifdef CTRL_M_EXT_EN
                end else if (funct7 == F7_MULDIV) begin
                    ctrl.alu_op     = ALU_MUL + 5'(funct3);
                    ctrl.multicycle = funct3[2];
`endif
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.ext_op    = EXT_I;
                ctrl.alu_op    = alu_base(funct3);
                uses_rs1       = 1'b1;
                // Shift-immediates reuse funct7 as an opcode extension, so it must be a defined value.
                if (funct3 == 3'b001) begin
                    ctrl.ext_op = EXT_SHAMT;
                    legal       = (funct7 == F7_BASE);
                end else if (funct3 == 3'b101) begin
                    ctrl.ext_op = EXT_SHAMT;
                    if (funct7 == F7_ALT) begin
                        ctrl.alu_op = ALU_SRA;
                    end else begin
                        legal = (funct7 == F7_BASE);
                    end
                end
            end
            OPC_LOAD: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.ext_op    = EXT_I;
                ctrl.alu_op    = ALU_ADD;
                ctrl.wd_sel    = WD_MEM;
                uses_rs1       = 1'b1;
                case (funct3)
                    3'b000:  ctrl.dm_ctrl = DM_B;
                    3'b001:  ctrl.dm_ctrl = DM_H;
                    3'b010:  ctrl.dm_ctrl = DM_W;
                    3'b100:  ctrl.dm_ctrl = DM_BU;
                    3'b101:  ctrl.dm_ctrl = DM_HU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.ext_op    = EXT_S;
                ctrl.alu_op    = ALU_ADD;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                case (funct3)
                    3'b000:  ctrl.dm_ctrl = DM_B;
                    3'b001:  ctrl.dm_ctrl = DM_H;
                    3'b010:  ctrl.dm_ctrl = DM_W;
                    default: legal = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                ctrl.ext_op = EXT_B;
                ctrl.npc_op = NPC_BRANCH;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                case (funct3)
                    3'b000:  ctrl.alu_op = ALU_BEQ;
                    3'b001:  ctrl.alu_op = ALU_BNE;
                    3'b100:  ctrl.alu_op = ALU_BLT;
                    3'b101:  ctrl.alu_op = ALU_BGE;
                    3'b110:  ctrl.alu_op = ALU_BLTU;
                    3'b111:  ctrl.alu_op = ALU_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.ext_op    = EXT_J;
                ctrl.npc_op    = NPC_JAL;
                ctrl.wd_sel    = WD_PC;
            end
            OPC_JALR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.ext_op    = EXT_I;
                ctrl.alu_op    = ALU_ADD;
                ctrl.npc_op    = NPC_JALR;
                ctrl.wd_sel    = WD_PC;
                uses_rs1       = 1'b1;
                legal          = (funct3 == 3'b000);
            end
            OPC_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.ext_op    = EXT_U;
                ctrl.alu_op    = ALU_LUI;
            end
            OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.ext_op    = EXT_U;
                ctrl.alu_op    = ALU_AUIPC;
            end
            default: legal = 1'b0;
        endcase

        // An undecodable word reads no registers, so it never causes a load-use stall.
        if (!legal) begin
            ctrl         = CTRL_NOP;
            ctrl.illegal = 1'b1;
            uses_rs1     = 1'b0;
            uses_rs2     = 1'b0;
        end
    end

    assign ctrl_o     = ctrl;
    assign uses_rs1_o = uses_rs1;
    assign uses_rs2_o = uses_rs2;

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered RV32I decode stage between IF/ID and ID/EX with valid/ready handshakes, flush and load-use bubbles.
// Define CTRL_M_EXT_EN to decode the M extension; otherwise those encodings are flagged illegal.
module decode_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [REG_AW-1:0] out_rd,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic              out_RegWrite,
    output logic              out_MemWrite,
    output logic              out_ALUSrc,
    output logic [5:0]        out_EXTOp,
    output logic [4:0]        out_ALUOp,
    output logic [2:0]        out_NPCOp,
    output logic [1:0]        out_WDSel,
    output logic [2:0]        out_dm_ctrl,
    output logic              out_illegal,
    output logic              out_multicycle
);

    logic [CTRL_W-1:0] ctrl_bits;
    ctrl_t             ctrl_d;
    logic              uses_rs1;
    logic              uses_rs2;
    logic [4:0]        rd_f;
    logic [4:0]        rs1_f;
    logic [4:0]        rs2_f;
    logic [REG_AW-1:0] rd_d;
    logic [REG_AW-1:0] rs1_d;
    logic [REG_AW-1:0] rs2_d;

    state_e            state_q;
    logic              valid_q;
    ctrl_t             ctrl_q;
    logic [PC_W-1:0]   pc_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;

    logic              hazard;
    logic              accept;

    decode_ctrl_comb u_decode (
        .instr_i    (in_instr),
        .ctrl_o     (ctrl_bits),
        .uses_rs1_o (uses_rs1),
        .uses_rs2_o (uses_rs2),
        .rd_o       (rd_f),
        .rs1_o      (rs1_f),
        .rs2_o      (rs2_f)
    );

    assign ctrl_d = ctrl_t'(ctrl_bits);
    assign rd_d   = REG_AW'(rd_f);
    assign rs1_d  = REG_AW'(rs1_f);
    assign rs2_d  = REG_AW'(rs2_f);

    // A load still in the output register cannot forward its data to the instruction behind it.
    assign hazard = valid_q && (ctrl_q.wd_sel == WD_MEM) && (rd_q != '0) &&
                    ((uses_rs1 && (rs1_d == rd_q)) || (uses_rs2 && (rs2_d == rd_q)));

    assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_RUN;
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            pc_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else if (flush) begin
            state_q <= ST_RUN;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        valid_q <= 1'b1;
                        ctrl_q  <= ctrl_d;
                        pc_q    <= in_pc;
                        rd_q    <= rd_d;
                        rs1_q   <= rs1_d;
                        rs2_q   <= rs2_d;
                    end else if (hazard && out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_BUBBLE;
                    end else if (out_ready) begin
                        valid_q <= 1'b0;
                    end
                end
                ST_BUBBLE: begin
                    if (accept) begin
                        valid_q <= 1'b1;
                        ctrl_q  <= ctrl_d;
                        pc_q    <= in_pc;
                        rd_q    <= rd_d;
                        rs1_q   <= rs1_d;
                        rs2_q   <= rs2_d;
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign out_valid      = valid_q;
    assign out_pc         = pc_q;
    assign out_rd         = rd_q;
    assign out_rs1        = rs1_q;
    assign out_rs2        = rs2_q;
    assign out_RegWrite   = ctrl_q.reg_write;
    assign out_MemWrite   = ctrl_q.mem_write;
    assign out_ALUSrc     = ctrl_q.alu_src;
    assign out_EXTOp      = ctrl_q.ext_op;
    assign out_ALUOp      = ctrl_q.alu_op;
    assign out_NPCOp      = ctrl_q.npc_op;
    assign out_WDSel      = ctrl_q.wd_sel;
    assign out_dm_ctrl    = ctrl_q.dm_ctrl;
    assign out_illegal    = ctrl_q.illegal;
    assign out_multicycle = ctrl_q.multicycle;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboard bench for decode_ctrl_stage: a table-driven instruction model predicts each bundle and the stall behaviour.
// Directed cases cover the documented scenarios; a randomized phase mixes handshakes, flushes and load-use pairs.
module tb_decode_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic        out_RegWrite;
    logic        out_MemWrite;
    logic        out_ALUSrc;
    logic [5:0]  out_EXTOp;
    logic [4:0]  out_ALUOp;
    logic [2:0]  out_NPCOp;
    logic [1:0]  out_WDSel;
    logic [2:0]  out_dm_ctrl;
    logic        out_illegal;
    logic        out_multicycle;

    always #5 clk = ~clk;

    decode_ctrl_stage #(.PC_W(32), .REG_AW(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_rd         (out_rd),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .out_RegWrite   (out_RegWrite),
        .out_MemWrite   (out_MemWrite),
        .out_ALUSrc     (out_ALUSrc),
        .out_EXTOp      (out_EXTOp),
        .out_ALUOp      (out_ALUOp),
        .out_NPCOp      (out_NPCOp),
        .out_WDSel      (out_WDSel),
        .out_dm_ctrl    (out_dm_ctrl),
        .out_illegal    (out_illegal),
        .out_multicycle (out_multicycle)
    );

    typedef struct packed {
        logic       rw;
        logic       mw;
        logic       src;
        logic [5:0] ext;
        logic [4:0] alu;
        logic [2:0] npc;
        logic [1:0] wd;
        logic [2:0] dm;
        logic       ill;
        logic       mc;
    } bundle_t;

    // f3/f7 of -1 mean those bits are immediate, not part of the encoding.
    typedef struct {
        logic [6:0] opc;
        int         f3;
        int         f7;
        bundle_t    b;
        bit         u1;
        bit         u2;
    } ent_t;

    typedef struct {
        bundle_t     b;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        bit          u1;
        bit          u2;
    } exp_t;

    localparam logic [5:0] X_SH = 6'b100000;
    localparam logic [5:0] X_I  = 6'b010000;
    localparam logic [5:0] X_S  = 6'b001000;
    localparam logic [5:0] X_B  = 6'b000100;
    localparam logic [5:0] X_U  = 6'b000010;
    localparam logic [5:0] X_J  = 6'b000001;
    localparam logic [4:0] A_ADD = 5'b00011;

    ent_t    tbl[$];
    int      loads[$];
    exp_t    sb[$];
    int      checks = 0;
    int      errors = 0;
    bundle_t dut_b;

    assign dut_b = {out_RegWrite, out_MemWrite, out_ALUSrc, out_EXTOp, out_ALUOp,
                    out_NPCOp, out_WDSel, out_dm_ctrl, out_illegal, out_multicycle};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bundle_t bun(logic rw, logic mw, logic src, logic [5:0] ext, logic [4:0] alu,
                                    logic [2:0] npc, logic [1:0] wd, logic [2:0] dm, logic mc);
        bundle_t b;
        b = {rw, mw, src, ext, alu, npc, wd, dm, 1'b0, mc};
        return b;
    endfunction

    function automatic void add(logic [6:0] opc, int f3, int f7, bundle_t b, bit u1, bit u2);
        ent_t e;
        e.opc = opc; e.f3 = f3; e.f7 = f7; e.b = b; e.u1 = u1; e.u2 = u2;
        tbl.push_back(e);
    endfunction

    function automatic void r_op(int f3, int f7, logic [4:0] alu);
        add(7'b0110011, f3, f7, bun(1, 0, 0, 6'b0, alu, 3'b000, 2'b00, 3'b000, 0), 1, 1);
    endfunction

    function automatic void i_op(int f3, int f7, logic [4:0] alu, logic [5:0] ext);
        add(7'b0010011, f3, f7, bun(1, 0, 1, ext, alu, 3'b000, 2'b00, 3'b000, 0), 1, 0);
    endfunction

    function automatic void ld(int f3, logic [2:0] dm);
        add(7'b0000011, f3, -1, bun(1, 0, 1, X_I, A_ADD, 3'b000, 2'b01, dm, 0), 1, 0);
        loads.push_back(tbl.size() - 1);
    endfunction

    function automatic void st(int f3, logic [2:0] dm);
        add(7'b0100011, f3, -1, bun(0, 1, 1, X_S, A_ADD, 3'b000, 2'b00, dm, 0), 1, 1);
    endfunction

    function automatic void br(int f3, logic [4:0] alu);
        add(7'b1100011, f3, -1, bun(0, 0, 0, X_B, alu, 3'b001, 2'b00, 3'b000, 0), 1, 1);
    endfunction

    // The instruction set as a mnemonic table, written straight from the RV32I encoding list.
    function automatic void build();
        r_op(0, 7'h00, 5'b00011); r_op(0, 7'h20, 5'b00100); r_op(1, 7'h00, 5'b01111);
        r_op(2, 7'h00, 5'b01010); r_op(3, 7'h00, 5'b01011); r_op(4, 7'h00, 5'b01100);
        r_op(5, 7'h00, 5'b10000); r_op(5, 7'h20, 5'b10001); r_op(6, 7'h00, 5'b01101);
        r_op(7, 7'h00, 5'b01110);
        i_op(0, -1, 5'b00011, X_I); i_op(2, -1, 5'b01010, X_I); i_op(3, -1, 5'b01011, X_I);
        i_op(4, -1, 5'b01100, X_I); i_op(6, -1, 5'b01101, X_I); i_op(7, -1, 5'b01110, X_I);
        i_op(1, 7'h00, 5'b01111, X_SH); i_op(5, 7'h00, 5'b10000, X_SH); i_op(5, 7'h20, 5'b10001, X_SH);
        ld(0, 3'b011); ld(1, 3'b001); ld(2, 3'b000); ld(4, 3'b100); ld(5, 3'b010);
        st(0, 3'b011); st(1, 3'b001); st(2, 3'b000);
        br(0, 5'b00100); br(1, 5'b00101); br(4, 5'b00110); br(5, 5'b00111); br(6, 5'b01000); br(7, 5'b01001);
        add(7'b1101111, -1, -1, bun(1, 0, 0, X_J, 5'b00000, 3'b010, 2'b10, 3'b000, 0), 0, 0);
        add(7'b1100111, 0, -1, bun(1, 0, 1, X_I, A_ADD, 3'b100, 2'b10, 3'b000, 0), 1, 0);
        add(7'b0110111, -1, -1, bun(1, 0, 1, X_U, 5'b00001, 3'b000, 2'b00, 3'b000, 0), 0, 0);
        add(7'b0010111, -1, -1, bun(1, 0, 1, X_U, 5'b00010, 3'b000, 2'b00, 3'b000, 0), 0, 0);
`ifdef CTRL_M_EXT_EN
        for (int f = 0; f < 8; f++)
            r_op_m(f);
`endif
    endfunction

`ifdef CTRL_M_EXT_EN
    function automatic void r_op_m(int f);
        logic [4:0] a;
        a = 5'(18 + f);
        add(7'b0110011, f, 7'h01, bun(1, 0, 0, 6'b0, a, 3'b000, 2'b00, 3'b000, (f >= 4)), 1, 1);
    endfunction
`endif

    // Anything not found in the table is illegal and reads no registers.
    function automatic exp_t model(logic [31:0] ins, logic [31:0] pc);
        exp_t e;
        bit   found;
        e.b = '0; e.b.ill = 1'b1; e.u1 = 0; e.u2 = 0;
        e.pc = pc; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
        found = 0;
        foreach (tbl[i]) begin
            if (!found && tbl[i].opc == ins[6:0] &&
                (tbl[i].f3 < 0 || tbl[i].f3 == int'(ins[14:12])) &&
                (tbl[i].f7 < 0 || tbl[i].f7 == int'(ins[31:25]))) begin
                found = 1;
                e.b = tbl[i].b; e.u1 = tbl[i].u1; e.u2 = tbl[i].u2;
            end
        end
        return e;
    endfunction

    function automatic logic [4:0] pick_reg();
        logic [4:0] r;
        r = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
        return r;
    endfunction

    function automatic logic [31:0] gen();
        int          k;
        ent_t        e;
        logic [31:0] w;
        int          f3;
        int          f7;
        k = $urandom_range(0, 99);
        w = $urandom;
        if (k < 12) return w;
        if (k < 35) e = tbl[loads[$urandom_range(0, loads.size() - 1)]];
        else        e = tbl[$urandom_range(0, tbl.size() - 1)];
        f3 = e.f3;
        f7 = e.f7;
        w[6:0] = e.opc;
        if (f3 >= 0) w[14:12] = f3[2:0];
        if (f7 >= 0) w[31:25] = f7[6:0];
        // Occasionally disturb funct3/funct7 to reach reserved encodings.
        if (k >= 35 && k < 45) w[31:25] = 7'($urandom);
        if (k >= 45 && k < 50) w[14:12] = 3'($urandom);
        w[11:7]  = pick_reg();
        w[19:15] = pick_reg();
        w[24:20] = pick_reg();
        return w;
    endfunction

    // Monitor: predicts in_ready/out_valid from the scoreboard and compares every presented bundle.
    always @(negedge clk) begin : monitor
        exp_t cur;
        bit   hz;
        bit   exp_rdy;
        if (rst) begin
            sb.delete();
        end else begin
            cur = model(in_instr, in_pc);
            hz = (sb.size() > 0) && (sb[0].b.wd == 2'b01) && (sb[0].rd != 5'd0) &&
                 ((cur.u1 && in_instr[19:15] == sb[0].rd) || (cur.u2 && in_instr[24:20] == sb[0].rd));
            exp_rdy = (sb.size() == 0 || out_ready) && !hz && !flush;
            check("in_ready", in_ready, exp_rdy);
            check("out_valid", out_valid, sb.size() != 0);
            if (out_valid && sb.size() > 0) begin
                check("bundle", dut_b, sb[0].b);
                check("pc", out_pc, sb[0].pc);
                check("regs", {out_rd, out_rs1, out_rs2}, {sb[0].rd, sb[0].rs1, sb[0].rs2});
            end
            if (sb.size() > 0 && (out_ready || flush)) void'(sb.pop_front());
            if (in_valid && exp_rdy) sb.push_back(cur);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc, output int stalls);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        stalls   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                step();
                in_valid = 1'b0;
                return;
            end
            stalls++;
            step();
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: instr %08h never accepted after %0d cycles", ins, stalls);
        in_valid = 1'b0;
    endtask

    initial begin
        int s;
        build();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_instr = '0; in_pc = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_bundle", dut_b, 0);
        check("rst_fields", {out_pc, out_rd, out_rs1, out_rs2}, 0);
        step();

        // add x3,x1,x2
        send(32'h002081B3, 32'h100, s);
        @(negedge clk);
        check("add_valid", out_valid, 1);
        check("add_aluop", out_ALUOp, 5'b00011);
        check("add_regwrite_alusrc", {out_RegWrite, out_ALUSrc}, 2'b10);
        check("add_rd", out_rd, 5'd3);
        step();

        // lw x5,0(x1) then dependent add x6,x5,x5
        send(32'h0000A283, 32'h104, s);
        in_valid = 1'b1; in_instr = 32'h00528333; in_pc = 32'h108;
        @(negedge clk);
        check("lw_wdsel_dm", {out_WDSel, out_dm_ctrl}, {2'b01, 3'b000});
        check("lu_stall_ready", in_ready, 0);
        step();
        @(negedge clk);
        check("bubble_valid", out_valid, 0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("lu_add_rd", {out_valid, out_rd}, {1'b1, 5'd6});
        step();

        // sw held for three cycles with out_ready low
        out_ready = 1'b0;
        send(32'h0020A023, 32'h10C, s);
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h110;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sw_hold", {out_valid, out_MemWrite, out_EXTOp, in_ready}, {1'b1, 1'b1, 6'b001000, 1'b0});
            check("sw_hold_pc", out_pc, 32'h10C);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();

        // flush kills a held beq
        out_ready = 1'b0;
        send(32'h00208063, 32'h114, s);
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("flush_valid", out_valid, 0);
        out_ready = 1'b1;
        step();
        send(32'h002081B3, 32'h118, s);
        check("after_flush_stalls", s, 0);

        // all-ones word is illegal but still occupies a slot
        send(32'hFFFFFFFF, 32'h11C, s);
        @(negedge clk);
        check("illegal", {out_valid, out_illegal, out_RegWrite, out_MemWrite, out_NPCOp}, {1'b1, 1'b1, 1'b0, 1'b0, 3'b000});
        step();

        send(32'h022081B3, 32'h120, s);
        @(negedge clk);
`ifdef CTRL_M_EXT_EN
        check("mul", {out_illegal, out_ALUOp, out_multicycle}, {1'b0, 5'b10010, 1'b0});
`else
        check("mul_illegal", {out_illegal, out_RegWrite, out_multicycle}, {1'b1, 1'b0, 1'b0});
`endif
        step();
        send(32'h0220C1B3, 32'h124, s);
        @(negedge clk);
`ifdef CTRL_M_EXT_EN
        check("div", {out_illegal, out_ALUOp, out_multicycle}, {1'b0, 5'b10110, 1'b1});
`else
        check("div_illegal", {out_illegal, out_multicycle}, {1'b1, 1'b0});
`endif
        step();

        // reset while a bubble is in flight
        send(32'h0000A283, 32'h128, s);
        in_valid = 1'b1; in_instr = 32'h00528333; in_pc = 32'h12C;
        step();
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_bubble", {out_valid, in_ready}, 2'b01);
        step();

        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_instr  = gen();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
